// File: rtl/tristate_buffer_pkg.sv
// Shared constants for the tristate_buffer bus-driver slice.
// Default widths and the high-impedance bit used to build released words.
package tristate_buffer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Replicate to WIDTH to form the all-Z released bus word.
  localparam logic Z_BIT = 1'bz;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Ports: clk, rst (sync clear), inc (count enable), count (value).
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Stick at all-ones instead of wrapping.
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tristate_buffer.sv
// Bus-driver stage: drives a onto y while enabled, else releases to Z.
// Ports: clk, rst, a, en in; y (tri bus), oe_q, drive_cycles out.
module tristate_buffer
  import tristate_buffer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REGISTERED = 0,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output wire  [WIDTH-1:0] y,
  output logic             oe_q,
  output logic [CNT_W-1:0] drive_cycles
);

  logic             oe;
  logic [WIDTH-1:0] drv;
  logic             oe_d;

  generate
    if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] a_d;
      logic             en_q;
      logic             en_d;

      // Reset wins over the sampled inputs so the bus lets go at once.
      always_comb begin
        a_d  = a;
        en_d = en;
        if (rst) begin
          a_d  = '0;
          en_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        a_q  <= a_d;
        en_q <= en_d;
      end

      assign oe  = en_q;
      assign drv = a_q;
    end else begin : g_comb
      // Pure wire path; rst only touches the status flops.
      assign oe  = en;
      assign drv = a;
    end
  endgenerate

  assign y = oe ? drv : {WIDTH{Z_BIT}};

  always_comb begin
    oe_d = rst ? 1'b0 : en;
  end

  always_ff @(posedge clk) begin
    oe_q <= oe_d;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (en),
    .count (drive_cycles)
  );

endmodule

// File: tb/tb_tristate_buffer.sv
// Directed bench for tristate_buffer in combinational, registered
// and narrow-counter configurations; Z is sensed via pull resistors.
module tb_tristate_buffer;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       en;

  wire  [3:0] cpu_y;
  wire  [3:0] cpd_y;
  wire  [3:0] rpu_y;
  wire  [3:0] rpd_y;
  wire  [3:0] s_y;

  logic       cpu_oe, cpd_oe, rpu_oe, rpd_oe, s_oe;
  logic [7:0] cpu_cnt, cpd_cnt, rpu_cnt, rpd_cnt;
  logic [1:0] s_cnt;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_pull
    pullup   (cpu_y[i]);
    pulldown (cpd_y[i]);
    pullup   (rpu_y[i]);
    pulldown (rpd_y[i]);
  end

  tristate_buffer #(.WIDTH(4), .REGISTERED(0), .CNT_W(8)) u_cpu (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(cpu_y),
    .oe_q(cpu_oe), .drive_cycles(cpu_cnt));
  tristate_buffer #(.WIDTH(4), .REGISTERED(0), .CNT_W(8)) u_cpd (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(cpd_y),
    .oe_q(cpd_oe), .drive_cycles(cpd_cnt));
  tristate_buffer #(.WIDTH(4), .REGISTERED(1), .CNT_W(8)) u_rpu (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(rpu_y),
    .oe_q(rpu_oe), .drive_cycles(rpu_cnt));
  tristate_buffer #(.WIDTH(4), .REGISTERED(1), .CNT_W(8)) u_rpd (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(rpd_y),
    .oe_q(rpd_oe), .drive_cycles(rpd_cnt));
  tristate_buffer #(.WIDTH(4), .REGISTERED(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(s_y),
    .oe_q(s_oe), .drive_cycles(s_cnt));

  typedef struct {
    logic [3:0] a;
    logic       en;
    logic       expz;
    logic [3:0] expv;
  } vec_t;

  vec_t tbl [8];

  // Z shows as pull-up high on one copy and pull-down low on the other.
  task automatic chk_y(input string nm, input logic [3:0] pu,
                       input logic [3:0] pd, input logic expz,
                       input logic [3:0] expv);
    n_vec++;
    if (expz) begin
      if (!(pu == 4'hf && pd == 4'h0)) begin
        n_bad++;
        $display("FAIL %s: y pu=%b pd=%b, want zzzz", nm, pu, pd);
      end
    end else if (!(pu == expv && pd == expv)) begin
      n_bad++;
      $display("FAIL %s: y pu=%b pd=%b, want %b", nm, pu, pd, expv);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic [3:0] d);
    @(negedge clk);
    rst = r;
    en  = e;
    a   = d;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b0000, 1'b0, 1'b1, 4'b0000};
    tbl[1] = '{4'b0000, 1'b1, 1'b0, 4'b0000};
    tbl[2] = '{4'b1010, 1'b0, 1'b1, 4'b0000};
    tbl[3] = '{4'b1010, 1'b1, 1'b0, 4'b1010};
    tbl[4] = '{4'b0110, 1'b0, 1'b1, 4'b0000};
    tbl[5] = '{4'b0110, 1'b1, 1'b0, 4'b0110};
    tbl[6] = '{4'b1111, 1'b1, 1'b0, 4'b1111};
    tbl[7] = '{4'b1111, 1'b0, 1'b1, 4'b0000};

    rst = 1'b1;
    en  = 1'b0;
    a   = 4'b0000;

    drive(1'b1, 1'b0, 4'b0000);
    edge_wait();
    chk_n("rst_oe_comb", int'(cpu_oe), 0);
    chk_n("rst_oe_reg", int'(rpu_oe), 0);
    chk_n("rst_cnt_comb", int'(cpu_cnt), 0);
    chk_n("rst_cnt_sat", int'(s_cnt), 0);
    chk_y("rst_y_reg", rpu_y, rpd_y, 1'b1, 4'b0000);

    // Comb path follows a/en even while rst is held.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].en, tbl[i].a);
      chk_y($sformatf("tbl%0d_comb", i), cpu_y, cpd_y,
            tbl[i].expz, tbl[i].expv);
      chk_y($sformatf("tbl%0d_reg_in_rst", i), rpu_y, rpd_y,
            1'b1, 4'b0000);
      if (!tbl[i].expz) begin
        chk_n($sformatf("tbl%0d_sat_y", i), int'(s_y),
              int'(tbl[i].expv));
      end
    end
    edge_wait();
    chk_n("cnt_held_in_rst", int'(cpu_cnt), 0);

    // Registered latency: Z before edge N, data after it.
    drive(1'b0, 1'b1, 4'b1010);
    chk_y("reg_before_edge", rpu_y, rpd_y, 1'b1, 4'b0000);
    chk_y("comb_now", cpu_y, cpd_y, 1'b0, 4'b1010);
    edge_wait();
    chk_y("reg_after_edge", rpu_y, rpd_y, 1'b0, 4'b1010);
    chk_n("oe_comb_1", int'(cpu_oe), 1);
    chk_n("oe_reg_1", int'(rpu_oe), 1);
    chk_n("cnt_1", int'(cpu_cnt), 1);

    for (int k = 2; k <= 5; k++) begin
      drive(1'b0, 1'b1, 4'b1010);
      edge_wait();
    end
    chk_n("cnt_5", int'(cpu_cnt), 5);
    chk_n("sat_5", int'(s_cnt), 3);
    drive(1'b0, 1'b1, 4'b1010);
    edge_wait();
    chk_n("cnt_6", int'(cpu_cnt), 6);
    chk_n("sat_hold", int'(s_cnt), 3);

    // Dropping en: comb releases now, registered one edge later.
    drive(1'b0, 1'b0, 4'b1010);
    chk_y("comb_release", cpu_y, cpd_y, 1'b1, 4'b0000);
    chk_y("reg_still_drv", rpu_y, rpd_y, 1'b0, 4'b1010);
    edge_wait();
    chk_y("reg_release", rpu_y, rpd_y, 1'b1, 4'b0000);
    chk_n("oe_drop", int'(rpu_oe), 0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 4'b1010);
      edge_wait();
    end
    chk_n("cnt_hold_en0", int'(cpu_cnt), 6);
    chk_n("sat_hold_en0", int'(s_cnt), 3);

    // Reset in the middle of driving.
    drive(1'b0, 1'b1, 4'b0110);
    edge_wait();
    chk_y("mid_drv", rpu_y, rpd_y, 1'b0, 4'b0110);
    chk_n("cnt_7", int'(cpu_cnt), 7);
    drive(1'b1, 1'b1, 4'b0110);
    chk_y("comb_in_rst", cpu_y, cpd_y, 1'b0, 4'b0110);
    edge_wait();
    chk_y("mid_rst_y", rpu_y, rpd_y, 1'b1, 4'b0000);
    chk_n("mid_rst_cnt", int'(rpu_cnt), 0);
    chk_n("mid_rst_oe", int'(rpu_oe), 0);
    chk_n("mid_rst_sat", int'(s_cnt), 0);
    drive(1'b0, 1'b1, 4'b0110);
    chk_y("post_rst_pre", rpu_y, rpd_y, 1'b1, 4'b0000);
    edge_wait();
    chk_y("post_rst_y", rpu_y, rpd_y, 1'b0, 4'b0110);
    chk_n("post_rst_cnt", int'(rpu_cnt), 1);
    chk_n("post_rst_oe", int'(rpu_oe), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
